// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared widths, FSM state encoding and command record for the ULA controller
package ula_pkg;

  localparam int LARGURA = 6;
  localparam int N_REGS  = 4;
  localparam int IDX_W   = $clog2(N_REGS);
  localparam int OP_W    = 4;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    OPERANDOS = 2'd1,
    CAPTURA   = 2'd2,
    RESPOSTA  = 2'd3
  } estado_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [IDX_W-1:0] dest;
    logic [IDX_W-1:0] src_a;
    logic [IDX_W-1:0] src_b;
  } comando_t;

endpackage

// File: rtl/ula_banco_regs.sv
// rtl/ula_banco_regs.sv - register file, one write port, two combinational read ports, sync reset
module ula_banco_regs #(
  parameter int LARGURA = 6,
  parameter int N_REGS  = 4,
  parameter int IW      = $clog2(N_REGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [IW-1:0]      waddr,
  input  logic [LARGURA-1:0] wdata,
  input  logic [IW-1:0]      raddr_a,
  input  logic [IW-1:0]      raddr_b,
  output logic [LARGURA-1:0] rdata_a,
  output logic [LARGURA-1:0] rdata_b
);

  logic [LARGURA-1:0] regs [N_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/ula_controlador.sv
// rtl/ula_controlador.sv - sequences one ULA operation per command: fetch operands, drive ULA, capture, hand off result
module ula_controlador #(
  parameter int LARGURA = 6,
  parameter int N_REGS  = 4
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Cmd_valido,
  output logic                       Cmd_pronto,
  input  logic [3:0]                 Cmd_op,
  input  logic [$clog2(N_REGS)-1:0]  Cmd_dest,
  input  logic [$clog2(N_REGS)-1:0]  Cmd_srcA,
  input  logic [$clog2(N_REGS)-1:0]  Cmd_srcB,
  input  logic                       Carga_valida,
  input  logic [$clog2(N_REGS)-1:0]  Carga_end,
  input  logic [LARGURA-1:0]         Carga_dado,
  output logic [LARGURA-1:0]         ULA_A,
  output logic [LARGURA-1:0]         ULA_B,
  output logic [3:0]                 ULA_Sel,
  input  logic [LARGURA-1:0]         ULA_O,
  input  logic                       ULA_Overflow,
  input  logic                       ULA_Zero,
  output logic                       Res_valido,
  input  logic                       Res_pronto,
  output logic [LARGURA-1:0]         Res_dado,
  output logic                       Res_overflow,
  output logic                       Res_zero,
  output logic                       Ocupado
);

  import ula_pkg::*;

  localparam int IW = $clog2(N_REGS);

  estado_t            estado, prox_estado;
  comando_t           cmd_in;
  logic               aceita, captura;
  logic [IW-1:0]      dest_q;
  logic               rf_we;
  logic [IW-1:0]      rf_waddr;
  logic [LARGURA-1:0] rf_wdata, rd_a, rd_b;

  assign cmd_in = '{op: Cmd_op, dest: Cmd_dest, src_a: Cmd_srcA, src_b: Cmd_srcB};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox_estado;
    end
  end

  always_comb begin
    prox_estado = estado;
    aceita      = 1'b0;
    captura     = 1'b0;
    case (estado)
      OCIOSO: begin
        if (Cmd_valido) begin
          aceita      = 1'b1;
          prox_estado = OPERANDOS;
        end
      end
      OPERANDOS: prox_estado = CAPTURA;
      CAPTURA: begin
        captura     = 1'b1;
        prox_estado = RESPOSTA;
      end
      RESPOSTA: begin
        if (Res_pronto) begin
          prox_estado = OCIOSO;
        end
      end
      default: prox_estado = OCIOSO;
    endcase
  end

  // Operands are latched straight into the ULA-facing registers at acceptance,
  // so they are valid throughout OPERANDOS/CAPTURA and simply hold afterwards.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ULA_A        <= '0;
      ULA_B        <= '0;
      ULA_Sel      <= '0;
      dest_q       <= '0;
      Res_dado     <= '0;
      Res_overflow <= 1'b0;
      Res_zero     <= 1'b0;
    end else begin
      if (aceita) begin
        ULA_A   <= rd_a;
        ULA_B   <= rd_b;
        ULA_Sel <= cmd_in.op;
        dest_q  <= cmd_in.dest;
      end
      if (captura) begin
        Res_dado     <= ULA_O;
        Res_overflow <= ULA_Overflow;
        Res_zero     <= ULA_Zero;
      end
    end
  end

  // Loads and result write-back live in disjoint states, so one write port suffices.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = Carga_end;
    rf_wdata = Carga_dado;
    if (captura) begin
      rf_we    = 1'b1;
      rf_waddr = dest_q;
      rf_wdata = ULA_O;
    end else if (estado == OCIOSO && Carga_valida) begin
      rf_we = 1'b1;
    end
  end

  ula_banco_regs #(
    .LARGURA (LARGURA),
    .N_REGS  (N_REGS),
    .IW      (IW)
  ) u_banco (
    .clk     (Clock),
    .reset   (Reset),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (cmd_in.src_a),
    .raddr_b (cmd_in.src_b),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  assign Cmd_pronto = (estado == OCIOSO);
  assign Ocupado    = (estado != OCIOSO);
  assign Res_valido = (estado == RESPOSTA);

endmodule

// File: doc/ula_controlador.md
ULA_CONTROLADOR -- requirements
Module: ula_controlador

Interface
REQ-001 Parameter LARGURA, 6, operand/result width in bits.
REQ-002 Parameter N_REGS, 4, register-file depth; indices are $clog2(N_REGS) = 2 bits.
REQ-003 Clock  in  1  single clock; all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Cmd_valido  in  1  command request.
REQ-006 Cmd_pronto  out  1  controller can accept a command (state OCIOSO).
REQ-007 Cmd_op  in  4  ULA operation select, passed verbatim to ULA_Sel.
REQ-008 Cmd_dest, Cmd_srcA, Cmd_srcB  in  2 each  destination/source register indices.
REQ-009 Carga_valida  in  1  register-load strobe; Carga_end in 2, index; Carga_dado in 6, value.
REQ-010 ULA_A, ULA_B  out  6 each  operands to the ULA; ULA_Sel  out  4  operation to the ULA.
REQ-011 ULA_O  in  6; ULA_Overflow  in  1; ULA_Zero  in  1  combinational ULA result and flags.
REQ-012 Res_valido  out  1; Res_pronto  in  1  result handshake.
REQ-013 Res_dado  out  6; Res_overflow  out  1; Res_zero  out  1  registered result and flags.
REQ-014 Ocupado  out  1  high in every state except OCIOSO.

Function
REQ-015 FSM states: OCIOSO, OPERANDOS, CAPTURA, RESPOSTA; exactly one active.
REQ-016 OCIOSO: Cmd_pronto=1; Cmd_valido=1 latches op, dest, R[srcA], R[srcB] -> OPERANDOS.
REQ-017 OPERANDOS: ULA_A/ULA_B/ULA_Sel driven from latched values for one cycle -> CAPTURA.
REQ-018 CAPTURA: ULA_A/B/Sel held; ULA_O/Overflow/Zero registered into Res_*; R[dest] <= ULA_O -> RESPOSTA.
REQ-019 RESPOSTA: Res_valido=1; Res_* stable; Res_pronto=1 -> OCIOSO in the next cycle.
REQ-020 Latency: acceptance in cycle n -> Res_valido high from cycle n+3; minimum issue interval 4 cycles.
REQ-021 ULA_A/B/Sel hold last driven values outside OPERANDOS/CAPTURA.
REQ-022 Carga_valida writes R[Carga_end] <= Carga_dado only while in OCIOSO; ignored in other states.
REQ-023 Simultaneous Carga_valida and Cmd_valido in OCIOSO: the command latches pre-load register values; the load is still performed.
REQ-024 srcA == srcB legal; dest may equal a source; the write happens only in CAPTURA.
REQ-025 Res_pronto while Res_valido=0 is ignored; Res_valido never drops before handshake.
REQ-026 Flags are taken from the ULA unchanged; no recomputation.

Reset
REQ-027 Reset=1 at a clock edge: state <= OCIOSO; R[0..3], Res_dado, ULA_A, ULA_B <= 0; ULA_Sel <= 0; Res_overflow, Res_zero, Res_valido <= 0.
REQ-028 Reset mid-operation aborts: no register-file write; a pending result is discarded.
REQ-029 Reset dominates Cmd_valido and Carga_valida in the same cycle.

Structure
REQ-030 Package ula_pkg holds LARGURA, N_REGS, the state enum, and a command struct (op, dest, srcA, srcB).
REQ-031 One sub-module, ula_banco_regs: N_REGS x LARGURA register file with one write port, two combinational read ports, and synchronous reset.
REQ-032 The ULA itself is instantiated outside this block; the controller only drives and samples its ports.

Verification (bench ULA model: ULA_O = ULA_A + ULA_B when Sel=4'b0000, ULA_A & ULA_B when Sel=4'b1000; Zero/Overflow per result)
REQ-033 Load R0=6'd5, R1=6'd9; cmd op=0000, src 0,1, dest 2 -> ULA_A=5, ULA_B=9 at cycle n+1; Res_dado=14, zero=0, ovf=0 at n+3; R2=14.
REQ-034 R0=6'b101010, R1=6'b010101; op=1000 -> Res_dado=0, Res_zero=1, Res_overflow=0.
REQ-035 Hold Res_pronto=0 for 5 cycles -> Res_valido and Res_dado stable; Cmd_pronto=0; Carga to R3 ignored (R3 unchanged).
REQ-036 Same-cycle Carga R0=7 and cmd src R0 (old R0=2, R1=1, op=0000) -> Res_dado=3; R0=7 afterwards.
REQ-037 Reset asserted in CAPTURA -> next cycle OCIOSO, Res_valido=0, dest register unchanged at 0.
REQ-038 Back-to-back commands with Res_pronto tied high -> one acceptance every 4 cycles; results in order.
